// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: upstream FIFO read port plus the
// downstream valid/ready stream. master = the reader, slave = its environment.
interface fifo_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_rden;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      output fifo_rden,
      input  fifo_empty,
      input  fifo_data,
      output m_valid,
      input  m_ready,
      output m_data
   );

   modport slave (
      input  fifo_rden,
      output fifo_empty,
      output fifo_data,
      input  m_valid,
      output m_ready,
      input  m_data
   );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pulls len words from an upstream FIFO (one-cycle read
// latency) and forwards them on a valid/ready stream through a 2-entry skid
// buffer, sustaining one word per cycle when the sink is always ready.
module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] rd_count,
   fifo_reader_if.master        bus
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  remaining;
   logic                  vld_p1;      // a read was issued last cycle; fifo_data is live now
   logic [1:0]            occ;
   logic                  head;
   logic [DATA_WIDTH-1:0] skid [2];
   logic                  pop;
   logic                  tail;
   logic [1:0]            occ_after;   // occupancy once this cycle's push/pop settle
   logic                  rden;
   logic                  accept;

   assign pop       = (occ != 2'd0) && bus.m_ready;
   // A push only happens when at most one entry is held, so head+occ[0] is the free slot.
   assign tail      = head ^ occ[0];
   // pop implies occ>=1, so this never underflows; occ+vld_p1 never exceeds 2.
   assign occ_after = occ + {1'b0, vld_p1} - {1'b0, pop};
   assign accept    = (state == IDLE) && start;

   assign bus.m_valid   = (occ != 2'd0);
   assign bus.m_data    = skid[head];
   assign bus.fifo_rden = rden;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and control outputs; rden sees m_ready combinationally so a
   // slot freed this cycle can be refilled immediately.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      rden      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (len != '0) ? READ : FINISH;
         end
         READ: begin
            busy = 1'b1;
            rden = !bus.fifo_empty && (remaining != '0) && (occ_after < 2'd2);
            if (remaining == '0) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!vld_p1 && (occ == 2'd0)) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst bookkeeping: words still to request and words delivered downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         rd_count  <= '0;
      end else if (accept) begin
         remaining <= len;
         rd_count  <= '0;
      end else begin
         if (rden) remaining <= remaining - CNT_ONE;
         if (pop)  rd_count  <= rd_count + CNT_ONE;
      end
   end

   // Read-latency stage and skid buffer; reset empties it so nothing buffered
   // or in flight survives, and m_data reads back as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         occ     <= 2'd0;
         head    <= 1'b0;
         skid[0] <= '0;
         skid[1] <= '0;
      end else begin
         vld_p1 <= rden;
         if (vld_p1) skid[tail] <= bus.fifo_data;
         if (pop)    head <= ~head;
         occ <= occ_after;
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural upstream FIFO and a
// stream collector recording every accepted word and its cycle.
module tb_fifo_reader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] len;
   logic       busy;
   logic       done;
   logic [7:0] rd_count;

   fifo_reader_if #(.DATA_WIDTH(8)) bus ();

   fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .rd_count (rd_count),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream FIFO model and observers.
   logic [7:0] fq [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic [7:0] got [0:63];
   int         got_cyc [0:63];
   int         got_n = 0;
   int         rden_cnt = 0;
   int         done_cnt = 0;
   int         cyc = 0;

   int got0, rden0, done0;
   int n_cmp = 0;
   int n_bad = 0;

   assign bus.fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (bus.fifo_rden) begin
         bus.fifo_data <= fq[rd_ptr & 63];
         rd_ptr        <= rd_ptr + 1;
         rden_cnt      <= rden_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (bus.m_valid && bus.m_ready && got_n < 64) begin
         got[got_n]     <= bus.m_data;
         got_cyc[got_n] <= cyc;
         got_n          <= got_n + 1;
      end
      cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      fq[wr_ptr & 63] = v;
      wr_ptr++;
   endtask

   task automatic clr_obs();
      got0  = got_n;
      rden0 = rden_cnt;
      done0 = done_cnt;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int i;
      i = 0;
      while (done !== 1'b1 && i < limit) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_got(input string tag, input int n, input int limit);
      int i;
      i = 0;
      while ((got_n - got0) < n && i < limit) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_got"}, got_n - got0, n);
   endtask

   task automatic chk_words(input string tag, input int n, input logic [7:0] e [8], input bit consec);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_w%0d", tag, i), {24'd0, got[got0+i]}, {24'd0, e[i]});
         if (consec && i > 0)
            chk($sformatf("%s_gap%0d", tag, i), got_cyc[got0+i] - got_cyc[got0+i-1], 32'd1);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      len   = 8'd0;
      bus.m_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy",     {31'd0, busy},          32'd0);
      chk("rst_done",     {31'd0, done},          32'd0);
      chk("rst_rden",     {31'd0, bus.fifo_rden}, 32'd0);
      chk("rst_mvalid",   {31'd0, bus.m_valid},   32'd0);
      chk("rst_mdata",    {24'd0, bus.m_data},    32'd0);
      chk("rst_rdcount",  {24'd0, rd_count},      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero-length burst
      clr_obs();
      start = 1'b1; len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      chk("len0_done",    {31'd0, done}, 32'd1);
      chk("len0_busy",    {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("len0_done_lo", {31'd0, done}, 32'd0);
      chk("len0_rdens",   rden_cnt - rden0, 32'd0);
      chk("len0_dones",   done_cnt - done0, 32'd1);
      chk("len0_rdcount", {24'd0, rd_count}, 32'd0);

      // Basic 3-word burst, sink always ready
      push(8'h11); push(8'h22); push(8'h33);
      clr_obs();
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      chk("b3_busy", {31'd0, busy}, 32'd1);
      wait_done("b3", 20);
      chk("b3_busy_fin", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("b3_done_lo", {31'd0, done}, 32'd0);
      chk("b3_dones",   done_cnt - done0, 32'd1);
      chk("b3_words",   got_n - got0, 32'd3);
      chk_words("b3", 3, '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1);
      chk("b3_rdcount", {24'd0, rd_count}, 32'd3);
      chk("b3_rdens",   rden_cnt - rden0, 32'd3);

      // Back-pressure: sink stalled for 10 cycles
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      clr_obs();
      bus.m_ready = 1'b0;
      start = 1'b1; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("bp_rdens_a",  rden_cnt - rden0, 32'd2);
      chk("bp_valid_a",  {31'd0, bus.m_valid}, 32'd1);
      chk("bp_data_a",   {24'd0, bus.m_data},  32'hA1);
      repeat (5) @(negedge clk);
      chk("bp_rdens_b",  rden_cnt - rden0, 32'd2);
      chk("bp_data_b",   {24'd0, bus.m_data},  32'hA1);
      chk("bp_busy",     {31'd0, busy}, 32'd1);
      bus.m_ready = 1'b1;
      wait_done("bp", 20);
      @(negedge clk);
      chk("bp_words",   got_n - got0, 32'd4);
      chk_words("bp", 4, '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1);
      chk("bp_rdcount", {24'd0, rd_count}, 32'd4);
      chk("bp_rdens",   rden_cnt - rden0, 32'd4);

      // Upstream runs dry mid-burst
      push(8'hB1); push(8'hB2);
      clr_obs();
      start = 1'b1; len = 8'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("dry_busy",    {31'd0, busy}, 32'd1);
      chk("dry_words",   got_n - got0, 32'd2);
      chk("dry_rdcount", {24'd0, rd_count}, 32'd2);
      chk("dry_valid",   {31'd0, bus.m_valid}, 32'd0);
      chk("dry_rdens",   rden_cnt - rden0, 32'd2);
      push(8'hB3); push(8'hB4); push(8'hB5);
      wait_done("dry", 30);
      @(negedge clk);
      chk("dry_words_f", got_n - got0, 32'd5);
      chk_words("dry", 5, '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'h0, 8'h0, 8'h0}, 1'b0);
      chk("dry_rdcount_f", {24'd0, rd_count}, 32'd5);
      chk("dry_dones",     done_cnt - done0, 32'd1);

      // Reset in the middle of a 6-word burst
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5); push(8'hC6);
      clr_obs();
      start = 1'b1; len = 8'd6;
      @(negedge clk);
      start = 1'b0;
      wait_got("mrst", 2, 20);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy",    {31'd0, busy},          32'd0);
      chk("mrst_done",    {31'd0, done},          32'd0);
      chk("mrst_rden",    {31'd0, bus.fifo_rden}, 32'd0);
      chk("mrst_valid",   {31'd0, bus.m_valid},   32'd0);
      chk("mrst_data",    {24'd0, bus.m_data},    32'd0);
      chk("mrst_rdcount", {24'd0, rd_count},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_left", wr_ptr - rd_ptr, 32'd2);
      clr_obs();
      start = 1'b1; len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done("mrst2", 20);
      @(negedge clk);
      chk("mrst2_words", got_n - got0, 32'd2);
      chk_words("mrst2", 2, '{8'hC5, 8'hC6, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1);
      chk("mrst2_rdcount", {24'd0, rd_count}, 32'd2);

      // start while busy is ignored
      push(8'hD1); push(8'hD2); push(8'hD3);
      clr_obs();
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; len = 8'd7;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", {31'd0, busy}, 32'd1);
      wait_done("ign", 20);
      @(negedge clk);
      chk("ign_words", got_n - got0, 32'd3);
      chk_words("ign", 3, '{8'hD1, 8'hD2, 8'hD3, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 1'b1);
      chk("ign_rdens",   rden_cnt - rden0, 32'd3);
      chk("ign_dones",   done_cnt - done0, 32'd1);
      repeat (3) @(negedge clk);
      chk("ign_rdcount_hold", {24'd0, rd_count}, 32'd3);
      chk("ign_idle_busy",    {31'd0, busy},     32'd0);
      chk("ign_fifo_left",    wr_ptr - rd_ptr,   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO and stream data.
REQ-002 Parameter CNT_WIDTH, default 8: width of burst length and counters.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 len  input  CNT_WIDTH  number of words in the burst; sampled with start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse when a burst completes.
REQ-009 fifo_rden  output  1  read enable to the upstream FIFO.
REQ-010 fifo_empty  input  1  upstream FIFO empty flag.
REQ-011 fifo_data  input  DATA_WIDTH  upstream FIFO read data; valid one cycle after a rden edge.
REQ-012 m_valid  output  1  output stream word valid.
REQ-013 m_ready  input  1  downstream accepts the word.
REQ-014 m_data  output  DATA_WIDTH  output stream word.
REQ-015 rd_count  output  CNT_WIDTH  words delivered on m_* in the current or last burst.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, FINISH.
REQ-017 IDLE: start=1 with len!=0 latches len into remaining and clears rd_count, then goes to READ.
REQ-018 IDLE: start=1 with len=0 goes to FINISH and never asserts fifo_rden.
REQ-019 start outside IDLE is ignored, with no effect on any counter.
REQ-020 fifo_rden asserts only in READ, with fifo_empty=0, remaining>0 and (occ + inflight - pop) < 2.
REQ-021 In REQ-020, occ = skid entries (0..2), inflight = rden issued last cycle, pop = m_valid && m_ready.
REQ-022 The combinational path from m_ready to fifo_rden is intentional; it gives 1 word/cycle throughput.
REQ-023 Each asserted fifo_rden decrements remaining by 1 and sets inflight for the next cycle.
REQ-024 When inflight=1, fifo_data is written to the skid tail that cycle; otherwise fifo_data is ignored.
REQ-025 Skid buffer: 2-entry FIFO; m_valid = (occ!=0); m_data = head entry.
REQ-026 m_data stays stable while m_valid=1 and m_ready=0.
REQ-027 Push and pop in the same cycle leave occ unchanged; data order is preserved.
REQ-028 A word is transferred when m_valid && m_ready; rd_count then increments by 1.
REQ-029 READ goes to DRAIN in the cycle after remaining reaches 0.
REQ-030 DRAIN goes to FINISH when inflight=0, occ=0 and no transfer is pending.
REQ-031 FINISH asserts done for exactly one cycle, then returns to IDLE; busy=0 in FINISH and IDLE.
REQ-032 fifo_empty=1 mid-burst stalls reads indefinitely with no timeout; reads resume when it deasserts.
REQ-033 rd_count holds its final value in IDLE until the next accepted start.
REQ-034 No more than len words are ever read or emitted per burst.
REQ-035 remaining and rd_count do not wrap; the maximum burst is 2^CNT_WIDTH-1 words.

Reset
REQ-036 rst_n=0 asynchronously forces IDLE.
REQ-037 rst_n=0 clears occ, inflight, remaining and rd_count.
REQ-038 rst_n=0 forces busy=0, done=0, fifo_rden=0, m_valid=0 and m_data=0.
REQ-039 Reset mid-burst discards buffered and in-flight words; the data-in-flight cycle after reset release is ignored.
REQ-040 The first start after reset release behaves as from a clean IDLE.

Verification
REQ-041 FIFO preloaded 0x11,0x22,0x33; start len=3; m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, done pulses once, rd_count=3.
REQ-042 len=0 start -> done one cycle later, fifo_rden never asserts, rd_count=0.
REQ-043 len=4, FIFO holds 4 words, m_ready=0 for 10 cycles then 1 -> at most 2 rdens before m_ready rises, no loss, order preserved, m_data stable while stalled.
REQ-044 len=5, FIFO holds 2 words, 3 more written 20 cycles later -> stall with busy=1, then completion with 5 words in order and done.
REQ-045 rst_n pulsed low after 2 of 6 words delivered -> all outputs zero immediately; new start len=2 delivers the next 2 FIFO words correctly.
REQ-046 start pulsed during busy -> ignored; burst length and rd_count unchanged.
